// File: rtl/colour_pkg.sv
`default_nettype none
// ============================================================================
// Module  : colour_pkg
// Purpose : Shared types and helpers for the colour PWM driver.
//           - colour_t : 3-bit colour code from the lights controller
//           - rgb8_t   : 8-bit R/G/B intensity triple
//           - lut_rgb  : colour code -> 8-bit RGB duties
//           - is_invalid: codes that carry no colour (000, 111)
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package colour_pkg;

  // Resolution of the colour table; wider PWM counters scale from this.
  localparam int LUT_BITS = 8;

  typedef enum logic [2:0] {
    C_OFF    = 3'b000,
    C_RED    = 3'b001,
    C_ORANGE = 3'b010,
    C_YELLOW = 3'b011,
    C_GREEN  = 3'b100,
    C_BLUE   = 3'b101,
    C_VIOLET = 3'b110,
    C_ALL    = 3'b111
  } colour_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  function automatic rgb8_t lut_rgb(input colour_t code);
    rgb8_t rgb;
    case (code)
      C_RED:    rgb = {8'hFF, 8'h00, 8'h00};
      C_ORANGE: rgb = {8'hFF, 8'h80, 8'h00};
      C_YELLOW: rgb = {8'hFF, 8'hFF, 8'h00};
      C_GREEN:  rgb = {8'h00, 8'hFF, 8'h00};
      C_BLUE:   rgb = {8'h00, 8'h00, 8'hFF};
      C_VIOLET: rgb = {8'h80, 8'h00, 8'hFF};
      default:  rgb = {8'h00, 8'h00, 8'h00};
    endcase
    return rgb;
  endfunction

  function automatic logic is_invalid(input colour_t code);
    return (code == C_OFF) || (code == C_ALL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module  : pwm_channel
// Purpose : One LED channel: duty register, optional fade, registered compare.
//           The duty only moves at a period boundary, so a period is never
//           cut short or stretched mid-way.
// Config  : COLOUR_PWM_FADE_EN - duty ramps toward target by
//           FADE_STEP<<(PWM_BITS-8) per period instead of jumping.
// Ports   : clk, rst_n        clock, async active-low reset
//           enable            0 forces the output low
//           cnt               shared PWM counter
//           period_start      boundary strobe (cnt==0 while enabled)
//           target            scaled duty the channel should reach
//           pwm               registered PWM output
// Revision: 1.0 - initial release
// ============================================================================
module pwm_channel
  import colour_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int FADE_STEP = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic                period_start,
  input  logic [PWM_BITS-1:0] target,
  output logic                pwm
);

  if ((PWM_BITS < 8) || (PWM_BITS > 16) || (FADE_STEP < 1) || (FADE_STEP > 255))
  begin : g_bad_param
    $error("pwm_channel: PWM_BITS must be 8..16 and FADE_STEP 1..255");
  end

  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                pwm_q, pwm_d;

`ifdef COLOUR_PWM_FADE_EN
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(FADE_STEP) << (PWM_BITS - LUT_BITS);

  // Step toward target; the last step lands exactly on target.
  always_comb begin
    duty_d = duty_q;
    if (period_start) begin
      if (duty_q < target) begin
        duty_d = ((target - duty_q) <= STEP) ? target : (duty_q + STEP);
      end else if (duty_q > target) begin
        duty_d = ((duty_q - target) <= STEP) ? target : (duty_q - STEP);
      end
    end
  end
`else
  always_comb begin
    duty_d = duty_q;
    if (period_start) begin
      duty_d = target;
    end
  end
`endif

  // Compare against the post-boundary duty so the new value is visible on
  // the pin one clock after the boundary, starting with cnt==0.
  always_comb begin
    pwm_d = enable && (cnt < duty_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule
`default_nettype wire

// File: rtl/colour_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module  : colour_pwm_driver
// Purpose : Decodes the 3-bit colour code into RGB duties and drives three
//           glitch-free PWM LED pins. A new code is adopted only at a PWM
//           period boundary.
// Config  : COLOUR_PWM_FADE_EN - duties fade toward the new colour
//           (see pwm_channel); undefined = immediate change at boundary.
// Ports   : clk, rst_n        clock, async active-low reset
//           colour[2:0]       colour code from the lights controller
//           enable            1 = PWM running, 0 = outputs forced low
//           red/green/blue    LED PWM outputs
//           period_start      pulse while cnt==0 and enable==1
//           invalid           active code is 000 or 111
// Revision: 1.0 - initial release
// ============================================================================
module colour_pwm_driver
  import colour_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int FADE_STEP = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] colour,
  input  logic       enable,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic       period_start,
  output logic       invalid
);

  colour_t             code_q;
  colour_t             active_code_q, active_code_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                invalid_q, invalid_d;
  logic                boundary;
  rgb8_t               lut;
  logic [PWM_BITS-1:0] target [3];
  logic [2:0]          pwm;

  assign boundary = enable && (cnt_q == '0);

  always_comb begin
    cnt_d         = enable ? (cnt_q + PWM_BITS'(1)) : '0;
    active_code_d = boundary ? code_q : active_code_q;
    invalid_d     = enable && is_invalid(active_code_d);
    lut           = lut_rgb(active_code_d);
    target[0]     = PWM_BITS'(lut.r) << (PWM_BITS - LUT_BITS);
    target[1]     = PWM_BITS'(lut.g) << (PWM_BITS - LUT_BITS);
    target[2]     = PWM_BITS'(lut.b) << (PWM_BITS - LUT_BITS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q        <= C_OFF;
      active_code_q <= C_OFF;
      cnt_q         <= '0;
      invalid_q     <= 1'b0;
    end else begin
      code_q        <= colour_t'(colour);
      active_code_q <= active_code_d;
      cnt_q         <= cnt_d;
      invalid_q     <= invalid_d;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_chan
    pwm_channel #(
      .PWM_BITS (PWM_BITS),
      .FADE_STEP(FADE_STEP)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .cnt         (cnt_q),
      .period_start(boundary),
      .target      (target[i]),
      .pwm         (pwm[i])
    );
  end

  assign red   = pwm[0];
  assign green = pwm[1];
  assign blue  = pwm[2];

  // The counter already sits at 0 during reset; masking with rst_n keeps
  // the strobe quiet until the block is actually running.
  assign period_start = boundary && rst_n;
  assign invalid      = invalid_q;

endmodule
`default_nettype wire

// File: tb/tb_colour_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_colour_pwm_driver
// Purpose : Self-checking bench for colour_pwm_driver (PWM_BITS=8, no fade).
// Revision: 1.0 - initial release
// ============================================================================
module tb_colour_pwm_driver;

  localparam int PERIOD = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] colour = 3'b000;
  logic       enable = 1'b0;
  logic       red, green, blue, period_start, invalid;

  colour_pwm_driver #(
    .PWM_BITS (8),
    .FADE_STEP(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .colour      (colour),
    .enable      (enable),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .period_start(period_start),
    .invalid     (invalid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Colour table in duty units (out of 256 clocks).
  int lut [8][3] = '{'{0, 0, 0}, '{255, 0, 0}, '{255, 128, 0}, '{255, 255, 0},
                     '{0, 255, 0}, '{0, 0, 255}, '{128, 0, 255}, '{0, 0, 0}};

  // Reference model state.
  int m_cnt, m_code, m_active;
  int m_duty [3];
  bit m_out [3];
  bit m_inv;

  typedef struct {
    logic [2:0] colour;
    bit         en;
    int         r_hi, g_hi, b_hi, inv_hi;
  } vec_t;
  vec_t tbl [9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_code = 0; m_active = 0; m_inv = 0;
    for (int i = 0; i < 3; i++) begin
      m_duty[i] = 0;
      m_out[i]  = 0;
    end
  endtask

  // One rising edge with the given inputs applied.
  task automatic model_edge(input int c, input bit en);
    if (en) begin
      if (m_cnt == 0) begin
        m_active = m_code;
        for (int i = 0; i < 3; i++) m_duty[i] = lut[m_active][i];
      end
      for (int i = 0; i < 3; i++) m_out[i] = (m_cnt < m_duty[i]);
      m_inv = (m_active == 0) || (m_active == 7);
      m_cnt = (m_cnt + 1) % PERIOD;
    end else begin
      m_cnt = 0;
      m_inv = 0;
      for (int i = 0; i < 3; i++) m_out[i] = 0;
    end
    m_code = c;
  endtask

  task automatic step(input logic [2:0] c, input bit en);
    logic [4:0] expv;
    colour = c;
    enable = en;
    @(posedge clk);
    model_edge(int'(c), en);
    #1;
    expv = {m_out[0], m_out[1], m_out[2], (en && (m_cnt == 0)), m_inv};
    check("cycle rgb/ps/inv", int'({red, green, blue, period_start, invalid}), int'(expv));
  endtask

  initial begin
    int rh, gh, bh, ih, lat, k;
    bit seen, en_r;
    logic [2:0] col_r;

    tbl[0] = '{3'b001, 1'b1, 255,   0,   0,   0};
    tbl[1] = '{3'b010, 1'b1, 255, 128,   0,   0};
    tbl[2] = '{3'b011, 1'b1, 255, 255,   0,   0};
    tbl[3] = '{3'b100, 1'b1,   0, 255,   0,   0};
    tbl[4] = '{3'b101, 1'b1,   0,   0, 255,   0};
    tbl[5] = '{3'b110, 1'b1, 128,   0, 255,   0};
    tbl[6] = '{3'b111, 1'b1,   0,   0,   0, 256};
    tbl[7] = '{3'b000, 1'b1,   0,   0,   0, 256};
    tbl[8] = '{3'b010, 1'b0,   0,   0,   0,   0};

    // Reset state, with enable already high.
    model_reset();
    enable = 1'b1;
    #12;
    check("reset outputs", int'({red, green, blue, period_start, invalid}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // colour=000 out of reset: invalid from the first period.
    step(3'b000, 1'b1);
    check("invalid after reset", int'(invalid), 1);
    repeat (20) step(3'b000, 1'b1);

    // Steady decode table.
    for (int v = 0; v < 9; v++) begin
      repeat (300) step(tbl[v].colour, tbl[v].en);
      rh = 0; gh = 0; bh = 0; ih = 0;
      repeat (PERIOD) begin
        step(tbl[v].colour, tbl[v].en);
        rh += int'(red); gh += int'(green); bh += int'(blue); ih += int'(invalid);
      end
      check($sformatf("red on-time code %0d en %0d", tbl[v].colour, tbl[v].en), rh, tbl[v].r_hi);
      check($sformatf("green on-time code %0d en %0d", tbl[v].colour, tbl[v].en), gh, tbl[v].g_hi);
      check($sformatf("blue on-time code %0d en %0d", tbl[v].colour, tbl[v].en), bh, tbl[v].b_hi);
      check($sformatf("invalid time code %0d en %0d", tbl[v].colour, tbl[v].en), ih, tbl[v].inv_hi);
    end

    // Boundary timing: 001 -> 100 while cnt==10.
    repeat (300) step(3'b001, 1'b1);
    k = 0;
    while (m_cnt != 10 && k < 300) begin
      step(3'b001, 1'b1);
      k++;
    end
    check("reach cnt 10", int'(m_cnt == 10), 1);
    seen = 0; lat = -1; rh = 0;
    for (int j = 1; j <= 260; j++) begin
      step(3'b100, 1'b1);
      if (!seen && green) begin
        seen = 1;
        lat  = j;
      end
      if (j <= 245 && red) rh++;
    end
    check("green latency after change", lat, 247);
    check("red held until wrap", rh, 245);

    // period_start spacing.
    k = 0;
    do begin
      step(3'b100, 1'b1);
      k++;
    end while (!period_start && k < 300);
    check("period_start seen", int'(period_start), 1);
    k = 0;
    do begin
      step(3'b100, 1'b1);
      k++;
    end while (!period_start && k < 300);
    check("period_start spacing", k, PERIOD);

    // Enable gating mid-period.
    k = 0;
    while (m_cnt != 100 && k < 300) begin
      step(3'b100, 1'b1);
      k++;
    end
    check("green high mid-period", int'(green), 1);
    step(3'b100, 1'b0);
    check("gated pins/ps", int'({red, green, blue, period_start}), 0);
    repeat (5) step(3'b100, 1'b0);
    enable = 1'b1;
    #1;
    check("period_start on first enabled clk", int'(period_start), 1);
    repeat (300) step(3'b100, 1'b1);

    // Reset mid-run while red is high.
    k = 0;
    do begin
      step(3'b001, 1'b1);
      k++;
    end while (!red && k < 600);
    check("red high before reset", int'(red), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset outputs", int'({red, green, blue, period_start, invalid}), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (600) step(3'b001, 1'b1);

    // Randomized run against the model.
    col_r = 3'b010;
    en_r  = 1'b1;
    repeat (4000) begin
      if ($urandom_range(63, 0) == 0) col_r = 3'($urandom_range(7, 0));
      if ($urandom_range(199, 0) == 0) en_r = ~en_r;
      step(col_r, en_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
